shift_add_multiplier: RTL
=========================

Name: shift_add_multiplier

Overview:
- Sequential 8x8 unsigned multiplier that sits directly upstream of EightBitAdder.
- Each iteration it drives the adder's bit-level operand inputs (x0..x7, y0..y7, cin) and consumes its sum and carry outputs (s0..s7, cout).
- It produces a 16-bit product through a start/done handshake.
- It is the first sequential stage built on the combinational adder.

Parameters:
- none; operand width is fixed at 8 by the EightBitAdder stage.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE and DONE.
- a  input  8  multiplicand, unsigned; captured when start is accepted.
- b  input  8  multiplier, unsigned; captured when start is accepted.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; product is valid from this cycle on.
- product  output  16  result register; holds its value until the next accepted start.

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high on rst. On an edge with rst=1:
  - state goes to IDLE;
  - busy=0, done=0, product=0x0000;
  - internal registers M, A, Q, C and cnt are all cleared.
- States: IDLE, RUN, DONE (2-bit encoding).
- IDLE: busy=0, done=0. On start=1:
  - M<=a, Q<=b, A<=0, C<=0, cnt<=0;
  - move to RUN.
- RUN: busy=1. Adder inputs are x=A, y = Q[0] ? M : 0, cin=0. Each edge:
  - {C,A,Q} <= {cout, s, Q} >> 1 (logical right shift of the 17-bit value);
  - cnt <= cnt+1.
- RUN exit: on the edge where cnt==7 (the 8th iteration):
  - product <= {A_next, Q_next};
  - move to DONE.
- DONE: busy=0, done=1 for exactly one cycle.
  - Next edge: start=1 starts a new load (back-to-back, same as IDLE); otherwise go to IDLE.
- Latency: start is accepted at edge k.
  - busy is high for cycles k+1..k+8.
  - product updates at edge k+8; done is high in the cycle after edge k+8.
  - Throughput: at most one result per 9 cycles.
- start in RUN: ignored. Operands, cnt and the in-flight result are not disturbed.
- Input stability: a and b changing during RUN has no effect, because they were captured at load.
- Arithmetic: unsigned only; the 16-bit product cannot overflow.
  - The adder's cout is the 9th bit of the partial sum and must shift into A[7]; dropping it is a defect.
- product is written only at the end of RUN. It must not show partial values during RUN, and it holds across IDLE.
- Reset mid-operation: rst wins over every other event on the same edge.
  - The computation is aborted; no done pulse is generated.
  - product is cleared to 0x0000.
- Zero operands: a=0 or b=0 still takes the full 8 iterations. No early termination.

Decomposition:
- Shared package holds:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - ITERATIONS=8 and the counter width (3 bits).
- Sub-module: one existing EightBitAdder instance, wired bit-by-bit:
  - x0..x7 from A;
  - y0..y7 from the Q[0]-gated M;
  - cin tied to 0;
  - s0..s7 and cout into the shift datapath.
- Everything else (FSM, registers, shifter) lives in shift_add_multiplier. No further sub-modules.

Test Plan:
- Reset, then a=13 (0x0D), b=11 (0x0B), start pulse -> busy high 8 cycles; done one cycle later; product=0x008F; done low on the next cycle.
- a=0xFF, b=0xFF -> product=0xFE01. This exercises cout into A[7] on every iteration.
- a=0x00, b=0xFF, then a=0x80, b=0x02 back-to-back (second start held high during DONE) -> product=0x0000, then 0x0100. The second run starts with no IDLE cycle.
- Start a=0x05, b=0x03; during RUN pulse start with a=0xAA, b=0x55 -> second request ignored; product=0x000F; exactly one done pulse.
- Start a=0xFF, b=0xFF; assert rst at cycle 4 of RUN -> next cycle busy=0, done=0, product=0x0000; no done pulse. A subsequent start with a=2, b=3 gives product=0x0006.
- Idle hold: after a result of 0x008F, run 20 idle cycles with a and b toggling -> product stays 0x008F; busy and done stay 0.

Source files
------------

// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM encoding,
// datapath widths and the iteration count fixed by the 8-bit adder stage.
package shift_add_multiplier_pkg;

  localparam int unsigned OP_W       = 8;
  localparam int unsigned PROD_W     = 2 * OP_W;
  localparam int unsigned ITERATIONS = 8;
  localparam int unsigned CNT_W      = 3;

  // Counter value seen on the final RUN edge.
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERATIONS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Partial-product addend: the multiplicand when the current multiplier bit is set.
  function automatic logic [OP_W-1:0] gate_addend(input logic [OP_W-1:0] m,
                                                  input logic            sel);
    return sel ? m : '0;
  endfunction

endpackage : shift_add_multiplier_pkg

// File: rtl/EightBitAdder.sv
// Combinational 8-bit ripple adder with bit-level operand ports.
// Ports: x0..x7, y0..y7 operands (LSB first), cin carry-in;
//        s0..s7 sum bits, cout carry-out (9th bit of the sum).
module EightBitAdder (
  input  logic x0,
  input  logic x1,
  input  logic x2,
  input  logic x3,
  input  logic x4,
  input  logic x5,
  input  logic x6,
  input  logic x7,
  input  logic y0,
  input  logic y1,
  input  logic y2,
  input  logic y3,
  input  logic y4,
  input  logic y5,
  input  logic y6,
  input  logic y7,
  input  logic cin,
  output logic s0,
  output logic s1,
  output logic s2,
  output logic s3,
  output logic s4,
  output logic s5,
  output logic s6,
  output logic s7,
  output logic cout
);

  localparam int unsigned W = 8;

  logic [W-1:0] x_c;
  logic [W-1:0] y_c;
  logic [W-1:0] s_c;
  logic [W:0]   carry_c;

  assign x_c = {x7, x6, x5, x4, x3, x2, x1, x0};
  assign y_c = {y7, y6, y5, y4, y3, y2, y1, y0};

  // Ripple-carry chain of full adders.
  always_comb begin
    carry_c    = '0;
    s_c        = '0;
    carry_c[0] = cin;
    for (int i = 0; i < int'(W); i++) begin
      s_c[i]       = x_c[i] ^ y_c[i] ^ carry_c[i];
      carry_c[i+1] = (x_c[i] & y_c[i]) | (carry_c[i] & (x_c[i] ^ y_c[i]));
    end
  end

  assign {s7, s6, s5, s4, s3, s2, s1, s0} = s_c;
  assign cout = carry_c[W];

endmodule : EightBitAdder

// File: rtl/shift_add_multiplier.sv
// Sequential 8x8 unsigned shift-and-add multiplier with a start/done handshake.
// Ports: clk, rst (sync, active-high); start request; a multiplicand, b multiplier;
//        busy high while iterating; done one-cycle result pulse;
//        product 16-bit result register, held until the next completed run.
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [PROD_W-1:0] product
);

  state_t              state_q, state_d;
  logic [OP_W-1:0]     m_q, m_d;
  logic [OP_W-1:0]     a_q, a_d;
  logic [OP_W-1:0]     q_q, q_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [PROD_W-1:0]   product_q, product_d;

  logic [OP_W-1:0]     addend_c;
  logic [OP_W-1:0]     sum_c;
  logic                cout_c;
  logic [PROD_W-1:0]   shifted_c;

  assign addend_c = gate_addend(m_q, q_q[0]);

  // Partial-sum adder: x = A, y = gated M, no carry-in.
  EightBitAdder u_adder (
    .x0  (a_q[0]),
    .x1  (a_q[1]),
    .x2  (a_q[2]),
    .x3  (a_q[3]),
    .x4  (a_q[4]),
    .x5  (a_q[5]),
    .x6  (a_q[6]),
    .x7  (a_q[7]),
    .y0  (addend_c[0]),
    .y1  (addend_c[1]),
    .y2  (addend_c[2]),
    .y3  (addend_c[3]),
    .y4  (addend_c[4]),
    .y5  (addend_c[5]),
    .y6  (addend_c[6]),
    .y7  (addend_c[7]),
    .cin (1'b0),
    .s0  (sum_c[0]),
    .s1  (sum_c[1]),
    .s2  (sum_c[2]),
    .s3  (sum_c[3]),
    .s4  (sum_c[4]),
    .s5  (sum_c[5]),
    .s6  (sum_c[6]),
    .s7  (sum_c[7]),
    .cout(cout_c)
  );

  // {C,A,Q} <= {cout,s,Q} >> 1. The shifted-in top bit is always zero, so the
  // carry register C reads as zero between iterations and is folded away; the
  // adder's carry-out lands in A[7] and s[0] moves into Q[7].
  assign shifted_c = {cout_c, sum_c, q_q[OP_W-1:1]};

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      m_q       <= '0;
      a_q       <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      a_q       <= a_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    a_d       = a_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    product_d = product_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          m_d     = a;
          q_d     = b;
          a_d     = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        a_d    = shifted_c[PROD_W-1:OP_W];
        q_d    = shifted_c[OP_W-1:0];
        cnt_d  = cnt_q + CNT_W'(1);
        busy_d = 1'b1;
        if (cnt_q == LAST_ITER) begin
          product_d = shifted_c;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = ST_DONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule : shift_add_multiplier
